// File: rtl/divider_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | divider_pkg : shared types and op codes for the RV32M divider    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package divider_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] DIV  = 2'b00;
  localparam logic [1:0] DIVU = 2'b01;
  localparam logic [1:0] REM  = 2'b10;
  localparam logic [1:0] REMU = 2'b11;

  typedef struct packed {
    logic            enable;
    logic [1:0]      op;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic            clear;
  } div_in_type;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            ready;
  } div_out_type;

  function automatic logic [XLEN-1:0] twos_neg(input logic [XLEN-1:0] a);
    return ~a + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/divider_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | divider_if : request/response bundle between execute and divider |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface divider_if;
  import divider_pkg::*;

  div_in_type  req;
  div_out_type rsp;

  modport master (output req, input rsp);
  modport slave  (input req, output rsp);
endinterface
`default_nettype wire

// File: rtl/divider_div_step.sv
`default_nettype none
// +------------------------------------------------------------------+
// | div_step : one restoring shift/trial-subtract iteration          |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module div_step
  import divider_pkg::*;
(
  input  logic [XLEN:0]   rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvsr_i,
  output logic [XLEN:0]   rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN+1:0] shifted_w;
  logic [XLEN:0]   diff_w;
  logic            neg_w;

  assign shifted_w = {rem_i, quo_i[XLEN-1]};
  // Compare on the full shifted width so a stray top bit can never fake a fit.
  assign neg_w     = shifted_w < {2'b00, dvsr_i};
  assign diff_w    = shifted_w[XLEN:0] - {1'b0, dvsr_i};

  assign rem_o = neg_w ? shifted_w[XLEN:0] : diff_w;
  assign quo_o = {quo_i[XLEN-2:0], ~neg_w};

endmodule
`default_nettype wire

// File: rtl/divider.sv
`default_nettype none
// +------------------------------------------------------------------+
// | divider : iterative RV32M DIV/DIVU/REM/REMU unit, one bit/cycle  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module divider
  import divider_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  divider_if.slave   bus
);

  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            early_q, early_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            ready_q, ready_d;

  div_in_type      req_w;
  logic            signed_w;
  logic            a_neg_w;
  logic            b_neg_w;
  logic            ovf_w;
  logic [XLEN:0]   step_rem_w;
  logic [XLEN-1:0] step_quo_w;
  logic [XLEN-1:0] quo_fix_w;
  logic [XLEN-1:0] rem_fix_w;

  assign req_w    = bus.req;
  assign signed_w = ~req_w.op[0];
  assign a_neg_w  = signed_w & req_w.data1[XLEN-1];
  assign b_neg_w  = signed_w & req_w.data2[XLEN-1];
  assign ovf_w    = signed_w && (req_w.data1 == {1'b1, {(XLEN-1){1'b0}}})
                             && (req_w.data2 == {XLEN{1'b1}});

  assign quo_fix_w = qneg_q ? twos_neg(quo_q) : quo_q;
  assign rem_fix_w = rneg_q ? twos_neg(rem_q[XLEN-1:0]) : rem_q[XLEN-1:0];

  div_step u_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dvsr_i (dvsr_q),
    .rem_o  (step_rem_w),
    .quo_o  (step_quo_w)
  );

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    op_d      = op_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    early_d   = early_q;
    result_d  = result_q;
    ready_d   = 1'b0;

    if (req_w.clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_w.enable) begin
            op_d    = req_w.op;
            quo_d   = a_neg_w ? twos_neg(req_w.data1) : req_w.data1;
            dvsr_d  = b_neg_w ? twos_neg(req_w.data2) : req_w.data2;
            rem_d   = '0;
            qneg_d  = a_neg_w ^ b_neg_w;
            rneg_d  = a_neg_w;
            early_d = 1'b0;
            // Special cases publish their result straight away so ready lands in t+1.
            if (req_w.data2 == '0) begin
              quo_d    = '1;
              rem_d    = {1'b0, req_w.data1};
              qneg_d   = 1'b0;
              rneg_d   = 1'b0;
              early_d  = 1'b1;
              result_d = req_w.op[1] ? req_w.data1 : '1;
              ready_d  = 1'b1;
              state_d  = DONE;
            end else if (ovf_w) begin
              quo_d    = {1'b1, {(XLEN-1){1'b0}}};
              rem_d    = '0;
              qneg_d   = 1'b0;
              rneg_d   = 1'b0;
              early_d  = 1'b1;
              result_d = req_w.op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
              ready_d  = 1'b1;
              state_d  = DONE;
            end else begin
              counter_d = CNT_W'(XLEN - 1);
              state_d   = BUSY;
            end
          end
        end
        BUSY: begin
          rem_d = step_rem_w;
          quo_d = step_quo_w;
          if (counter_q == '0) begin
            state_d = DONE;
          end else begin
            counter_d = counter_q - 1'b1;
          end
        end
        DONE: begin
          state_d = IDLE;
          if (!early_q) begin
            result_d = op_q[1] ? rem_fix_w : quo_fix_w;
            ready_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      counter_q <= '0;
      op_q      <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      early_q   <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      op_q      <= op_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      early_q   <= early_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.rsp = '{result: result_q, ready: ready_q};

endmodule
`default_nettype wire

// File: tb/tb_divider.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_divider : directed and randomized checks of the divider       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_divider;
  import divider_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  divider_if bus();

  divider dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: RISC-V division semantics written directly with SV arithmetic.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, b);
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
      return op[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    end
    return op[1] ? a % b : a / b;
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, b);
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Issues one op in the current cycle and waits (bounded) for ready; lat=-1 on timeout.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, b,
                        output logic [31:0] res, output int lat);
    bus.req.enable = 1'b1;
    bus.req.op     = op;
    bus.req.data1  = a;
    bus.req.data2  = b;
    tick();
    bus.req.enable = 1'b0;
    lat = 1;
    while (bus.rsp.ready !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
    res = bus.rsp.result;
    if (bus.rsp.ready !== 1'b1) lat = -1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (bus.rsp.ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_ready got %b want 0", bus.rsp.ready);
    end
    n_cmp++;
    if (bus.rsp.result !== 32'd0) begin
      n_bad++; $display("FAIL reset_result got %h want 0", bus.rsp.result);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic [1:0]  ops  [8] = '{DIVU, REMU, DIV, REM, DIVU, REM, DIV, REM};
    logic [31:0] as   [8] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                              32'h1234_5678, 32'h1234_5678, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs   [8] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd0, 32'd0,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exps [8] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                              32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0000, 32'd0};
    int          lats [8] = '{34, 34, 34, 34, 1, 1, 1, 1};
    logic [31:0] res;
    int          lat;
    for (int i = 0; i < 8; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat);
      n_cmp++;
      if (lat != lats[i]) begin
        n_bad++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, lats[i]);
      end
      n_cmp++;
      if (res !== exps[i]) begin
        n_bad++; $display("FAIL dir%0d_result got %h want %h", i, res, exps[i]);
      end
      tick();
      n_cmp++;
      if (bus.rsp.ready !== 1'b0 || bus.rsp.result !== exps[i]) begin
        n_bad++; $display("FAIL dir%0d_pulse ready %b result %h want 0 / %h",
                          i, bus.rsp.ready, bus.rsp.result, exps[i]);
      end
    end
  endtask

  task automatic test_clear();
    logic [31:0] held, res;
    int          lat;
    bit          saw = 1'b0;
    held = bus.rsp.result;
    bus.req.enable = 1'b1; bus.req.op = DIVU;
    bus.req.data1 = 32'hFFFF_FFFF; bus.req.data2 = 32'd1;
    tick();
    bus.req.enable = 1'b0;
    repeat (9) begin
      if (bus.rsp.ready === 1'b1) saw = 1'b1;
      tick();
    end
    bus.req.clear = 1'b1;
    tick();
    bus.req.clear = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.rsp.ready === 1'b1) saw = 1'b1;
      if (i == 0) begin
        n_cmp++;
        if (bus.rsp.result !== held) begin
          n_bad++; $display("FAIL clear_result_held got %h want %h", bus.rsp.result, held);
        end
      end
      if (i == 0) begin
        tick();
        run_op(DIVU, 32'd9, 32'd3, res, lat);
        n_cmp++;
        if (lat != 34 || res !== 32'd3) begin
          n_bad++; $display("FAIL clear_next_op got %h lat %0d want 3 lat 34", res, lat);
        end
        break;
      end
    end
    n_cmp++;
    if (saw) begin
      n_bad++; $display("FAIL clear_no_pulse got ready=1 want no pulse");
    end
  endtask

  task automatic test_reset_mid();
    bit saw = 1'b0;
    bus.req.enable = 1'b1; bus.req.op = DIV;
    bus.req.data1 = 32'd1000; bus.req.data2 = 32'd7;
    tick();
    bus.req.enable = 1'b0;
    repeat (19) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (bus.rsp.ready !== 1'b0 || bus.rsp.result !== 32'd0) begin
      n_bad++; $display("FAIL reset_mid got ready %b result %h want 0 / 0",
                        bus.rsp.ready, bus.rsp.result);
    end
    repeat (30) begin
      tick();
      if (bus.rsp.ready === 1'b1) saw = 1'b1;
    end
    n_cmp++;
    if (saw) begin
      n_bad++; $display("FAIL reset_mid_no_pulse got ready=1 want no pulse");
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    int          lat;
    int          pulses = 0;
    bus.req.enable = 1'b1; bus.req.op = REMU;
    bus.req.data1 = 32'd1_000_003; bus.req.data2 = 32'd97;
    tick();
    lat = 1;
    // Hammer enable with different operands while the first op is running.
    while (bus.rsp.ready !== 1'b1 && lat < 60) begin
      bus.req.enable = lat[0];
      bus.req.op     = DIVU;
      bus.req.data1  = 32'($urandom);
      bus.req.data2  = 32'd0;
      tick();
      lat++;
    end
    bus.req.enable = 1'b0;
    res = bus.rsp.result;
    n_cmp++;
    if (lat != 34 || res !== 32'd1_000_003 % 32'd97) begin
      n_bad++; $display("FAIL busy_enable_ignored got %h lat %0d want %h lat 34",
                        res, lat, 32'd1_000_003 % 32'd97);
    end
    repeat (5) begin
      tick();
      if (bus.rsp.ready === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_bad++; $display("FAIL busy_enable_extra got %0d pulses want 0", pulses);
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b, res, exp_r;
    int          lat, exp_l;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = pick();
      b  = pick();
      exp_r = ref_div(op, a, b);
      exp_l = ref_lat(op, a, b);
      run_op(op, a, b, res, lat);
      n_cmp++;
      if (lat != exp_l || res !== exp_r) begin
        n_bad++; $display("FAIL rnd%0d op %0d a %h b %h got %h lat %0d want %h lat %0d",
                          i, op, a, b, res, lat, exp_r, exp_l);
      end
      tick();
      n_cmp++;
      if (bus.rsp.ready !== 1'b0 || bus.rsp.result !== exp_r) begin
        n_bad++; $display("FAIL rnd%0d_hold ready %b result %h want 0 / %h",
                          i, bus.rsp.ready, bus.rsp.result, exp_r);
      end
    end
  endtask

  initial begin
    bus.req = '0;
    test_reset();
    test_directed();
    test_clear();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
